uart_tx_arbiter: RTL

//   Shares the single UART TX path (toggle-strobed uart_tx_start/uart_tx_data_in, uart_tx_fifo_full

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam logic [7:0] HDR_TAG = 8'h80;
  localparam int         BURST_W = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin picker: first request at/after ptr, wrapping
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GNT_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [GNT_W-1:0]   idx_o,
  output logic               any_o
);

  int j;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = GNT_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet-atomic arbiter onto the toggle-strobed UART TX path
// Optional per-grant header byte (8'h80|winner) when UART_ARB_HDR_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64,
  parameter int WR_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ*8-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_last,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data_in,
  input  logic                 uart_tx_fifo_full
);

  localparam int GNT_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(WR_GAP + 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [GNT_W-1:0]     gidx_q, gidx_d;
  logic [GNT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 last_q, last_d;
  logic                 start_q, start_d;
  logic [7:0]           data_q, data_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [GNT_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic [GNT_W-1:0]     rr_next;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_picker (
    .req_i    (in_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign sel_data  = in_data[{gidx_q, 3'b000} +: 8];
  assign sel_valid = in_valid[gidx_q];
  assign sel_last  = in_last[gidx_q];
  // The owner just served drops to lowest priority for the next round.
  assign rr_next   = (gidx_q == GNT_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    gap_d    = gap_q;
    last_d   = last_q;
    start_d  = start_q;
    data_d   = data_q;
    in_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          burst_d = '0;
`ifdef UART_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      ST_HDR: begin
        if (!uart_tx_fifo_full) begin
          data_d  = HDR_TAG | 8'(gidx_q);
          start_d = ~start_q;
          last_d  = 1'b0;
          gap_d   = GAP_W'(WR_GAP);
          state_d = ST_GAP;
        end
      end
`endif
      ST_DATA: begin
        in_ready = grant_q & {NUM_REQ{~uart_tx_fifo_full}};
        if (sel_valid && !uart_tx_fifo_full) begin
          data_d  = sel_data;
          start_d = ~start_q;
          burst_d = burst_q + 1'b1;
          last_d  = sel_last;
          gap_d   = GAP_W'(WR_GAP);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q > GAP_W'(1)) begin
          gap_d = gap_q - 1'b1;
        end else begin
          gap_d = '0;
          if (last_q || burst_q == BURST_W'(MAX_BURST)) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      gap_q    <= '0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end

  assign grant           = grant_q;
  assign busy            = (state_q != ST_IDLE);
  assign uart_tx_start   = start_q;
  assign uart_tx_data_in = data_q;

endmodule
